// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch front end: fetch FSM states,
// word size, default reset address and the NOP encoding.
package mips_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

   localparam int unsigned WORD_BYTES       = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP              = 32'h0000_0000;

endpackage : mips_pkg

// File: rtl/pc_range_checker.sv
// Combinational legality check for a fetch byte address: it must be
// word-aligned and fall inside an instruction memory of limit_words words.
module pc_range_checker
   import mips_pkg::*;
(
   input  logic [31:0] addr,
   input  logic [31:0] limit_words,
   output logic        ok
);

   // Compare in 34 bits so a large word count cannot overflow the byte limit
   // and the full 32-bit address is always examined.
   logic [33:0] w_limit_bytes;

   assign w_limit_bytes = 34'(limit_words) * 34'(WORD_BYTES);
   assign ok            = (addr[1:0] == 2'b00) && ({2'b00, addr} < w_limit_bytes);

endmodule : pc_range_checker

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: sequential fetch with consumer backpressure,
// single-bubble redirects, and a sticky HALT on any illegal fetch address.
// The memory word arrives one cycle after ProgramCounter and is passed
// straight through as if_instruction.
module instruction_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned IMEM_WORDS = 32
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] ProgramCounter,
   input  logic [31:0] instruction,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] if_instruction,
   output logic [31:0] if_pc,
   output logic        if_valid,
   output logic        fetch_error,
   output logic [31:0] fetch_count
);

   localparam logic [31:0] LIMIT_WORDS = 32'(IMEM_WORDS);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;
   logic [31:0]  r_npc;
   logic [31:0]  w_npc_nxt;
   logic [31:0]  r_if_pc;
   logic [31:0]  w_if_pc_nxt;
   logic         r_if_valid;
   logic         w_if_valid_nxt;
   logic         r_last_word;      // the word now in if_pc is the last in memory
   logic         w_last_word_nxt;
   logic [31:0]  r_fetch_count;
   logic [31:0]  w_fetch_count_nxt;

   logic [31:0]  w_npc_plus;
   logic         w_redirect_ok;
   logic         w_seq_ok;
   logic         w_eff_stall;
   logic         w_accept;

   assign w_npc_plus  = r_npc + 32'(WORD_BYTES);
   assign w_eff_stall = stall && r_if_valid;
   assign w_accept    = r_if_valid && !stall;

   pc_range_checker u_redirect_check (
      .addr        (redirect_target),
      .limit_words (LIMIT_WORDS),
      .ok          (w_redirect_ok)
   );

   pc_range_checker u_seq_check (
      .addr        (w_npc_plus),
      .limit_words (LIMIT_WORDS),
      .ok          (w_seq_ok)
   );

   // State register and fetch datapath registers, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         r_state       <= RUN;
         r_npc         <= RESET_PC;
         r_if_pc       <= RESET_PC;
         r_if_valid    <= 1'b0;
         r_last_word   <= 1'b0;
         r_fetch_count <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_npc         <= w_npc_nxt;
         r_if_pc       <= w_if_pc_nxt;
         r_if_valid    <= w_if_valid_nxt;
         r_last_word   <= w_last_word_nxt;
         r_fetch_count <= w_fetch_count_nxt;
      end
   end

   // Next-state logic: redirect beats stall; an effective stall holds everything.
   always_comb begin
      // NOTE: hold-current defaults first so no path leaves a variable unassigned (no latches).
      w_state_nxt       = r_state;
      w_npc_nxt         = r_npc;
      w_if_pc_nxt       = r_if_pc;
      w_if_valid_nxt    = r_if_valid;
      w_last_word_nxt   = r_last_word;
      w_fetch_count_nxt = r_fetch_count;

      case (r_state)
         RUN: begin
            if (w_accept) begin
               w_fetch_count_nxt = r_fetch_count + 32'd1;
            end

            if (redirect) begin
               w_if_valid_nxt  = 1'b0;
               w_last_word_nxt = 1'b0;
               if (w_redirect_ok) begin
                  w_npc_nxt = redirect_target;
               end else begin
                  w_state_nxt = HALT;
               end
            end else if (w_eff_stall) begin
               // consumer holds the presented word; nothing advances
            end else if (r_last_word) begin
               // last legal word has just been taken; stop rather than wrap
               w_state_nxt    = HALT;
               w_if_valid_nxt = 1'b0;
            end else begin
               w_if_pc_nxt    = r_npc;
               w_if_valid_nxt = 1'b1;
               if (w_seq_ok) begin
                  w_npc_nxt = w_npc_plus;
               end else begin
                  w_last_word_nxt = 1'b1;
               end
            end
         end

         HALT: begin
            w_if_valid_nxt = 1'b0;
         end

         default: begin
            w_state_nxt    = HALT;
            w_if_valid_nxt = 1'b0;
         end
      endcase
   end

   // While the consumer stalls a valid word, keep re-reading that same word.
   assign ProgramCounter = (stall && r_if_valid) ? r_if_pc : r_npc;
   assign if_instruction = instruction;
   assign if_pc          = r_if_pc;
   assign if_valid       = r_if_valid;
   assign fetch_error    = (r_state == HALT);
   assign fetch_count    = r_fetch_count;

endmodule : instruction_fetch_unit

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run against a behavioural model of the fetch rules.
module tb_instruction_fetch_unit;
   import mips_pkg::*;

   localparam int unsigned IMEM_WORDS = 32;
   localparam logic [31:0] LAST_PC    = 32'(4 * IMEM_WORDS - 4);

   logic        clk;
   logic        reset;
   logic [31:0] ProgramCounter;
   logic [31:0] instruction;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] if_instruction;
   logic [31:0] if_pc;
   logic        if_valid;
   logic        fetch_error;
   logic [31:0] fetch_count;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mem [0:IMEM_WORDS-1];

   // behavioural model state
   logic [31:0] m_npc, m_if_pc, m_count;
   logic        m_valid, m_halted;

   instruction_fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .IMEM_WORDS (IMEM_WORDS)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .ProgramCounter  (ProgramCounter),
      .instruction     (instruction),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .if_instruction  (if_instruction),
      .if_pc           (if_pc),
      .if_valid        (if_valid),
      .fetch_error     (fetch_error),
      .fetch_count     (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous instruction memory: one-cycle read latency
   always @(posedge clk) instruction <= mem[ProgramCounter[6:2]];

   task automatic load_spec_program();
      for (int i = 0; i < IMEM_WORDS; i++) mem[i] = NOP;
      mem[3] = 32'h8C11_0008;
      mem[4] = 32'h8C12_0004;
      mem[5] = 32'h0232_4020;
   endtask

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      stall = 1'b0; redirect = 1'b0;
      reset = 1'b1;
      #1;
      n_cmp++; if (ProgramCounter !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", ProgramCounter); end
      n_cmp++; if (if_pc !== 32'h0) begin n_bad++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
      n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", if_valid); end
      n_cmp++; if (fetch_error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", fetch_error); end
      n_cmp++; if (fetch_count !== 32'h0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_sequential();
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         step_clk();
         n_cmp++; if (if_pc !== 32'(4 * (i - 1))) begin n_bad++; $display("FAIL seq_if_pc: got %h want %h", if_pc, 32'(4 * (i - 1))); end
         n_cmp++; if (ProgramCounter !== 32'(4 * i)) begin n_bad++; $display("FAIL seq_pc: got %h want %h", ProgramCounter, 32'(4 * i)); end
      end
      n_cmp++; if (if_instruction !== 32'h8C11_0008) begin n_bad++; $display("FAIL seq_instr: got %h want 8c110008", if_instruction); end
      n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL seq_valid: got %b want 1", if_valid); end
      n_cmp++; if (fetch_count !== 32'd3) begin n_bad++; $display("FAIL seq_count: got %0d want 3", fetch_count); end
   endtask

   // continues from if_pc=12
   task automatic test_stall();
      step_clk();
      n_cmp++; if (if_pc !== 32'd16 || if_instruction !== 32'h8C12_0004) begin n_bad++; $display("FAIL stall_entry: got pc %h instr %h want 10 8c120004", if_pc, if_instruction); end
      stall = 1'b1;
      #1;
      n_cmp++; if (ProgramCounter !== 32'd16) begin n_bad++; $display("FAIL stall_pc_comb: got %h want 10", ProgramCounter); end
      repeat (3) begin
         step_clk();
         n_cmp++; if (if_pc !== 32'd16 || if_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold: got pc %h valid %b want 10 1", if_pc, if_valid); end
         n_cmp++; if (if_instruction !== 32'h8C12_0004) begin n_bad++; $display("FAIL stall_instr: got %h want 8c120004", if_instruction); end
         n_cmp++; if (ProgramCounter !== 32'd16) begin n_bad++; $display("FAIL stall_pc: got %h want 10", ProgramCounter); end
         n_cmp++; if (fetch_count !== 32'd4) begin n_bad++; $display("FAIL stall_count: got %0d want 4", fetch_count); end
      end
      stall = 1'b0;
      step_clk();
      n_cmp++; if (if_pc !== 32'd20 || if_instruction !== 32'h0232_4020) begin n_bad++; $display("FAIL stall_release: got pc %h instr %h want 14 02324020", if_pc, if_instruction); end
      n_cmp++; if (fetch_count !== 32'd5) begin n_bad++; $display("FAIL stall_release_count: got %0d want 5", fetch_count); end
   endtask

   // continues from if_pc=20
   task automatic test_redirect();
      redirect = 1'b1; redirect_target = 32'd12;
      step_clk();
      redirect = 1'b0;
      n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL redir_bubble: got valid %b want 0", if_valid); end
      n_cmp++; if (fetch_count !== 32'd6) begin n_bad++; $display("FAIL redir_count: got %0d want 6", fetch_count); end
      n_cmp++; if (ProgramCounter !== 32'd12) begin n_bad++; $display("FAIL redir_pc: got %h want c", ProgramCounter); end
      step_clk();
      n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd12 || if_instruction !== 32'h8C11_0008) begin n_bad++; $display("FAIL redir_target: got v %b pc %h instr %h want 1 c 8c110008", if_valid, if_pc, if_instruction); end
      // redirect together with stall; keep stall high over the bubble
      redirect = 1'b1; stall = 1'b1; redirect_target = 32'd12;
      step_clk();
      redirect = 1'b0;
      n_cmp++; if (if_valid !== 1'b0 || fetch_count !== 32'd6) begin n_bad++; $display("FAIL redir_stall_bubble: got v %b cnt %0d want 0 6", if_valid, fetch_count); end
      step_clk();
      n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd12 || if_instruction !== 32'h8C11_0008) begin n_bad++; $display("FAIL redir_stall_target: got v %b pc %h instr %h want 1 c 8c110008", if_valid, if_pc, if_instruction); end
      stall = 1'b0;
   endtask

   // continues from if_pc=12, next fetch 16
   task automatic test_bad_redirect();
      redirect = 1'b1; redirect_target = 32'h0000_000A;
      step_clk();
      n_cmp++; if (fetch_error !== 1'b1 || if_valid !== 1'b0) begin n_bad++; $display("FAIL misaligned_halt: got err %b v %b want 1 0", fetch_error, if_valid); end
      n_cmp++; if (fetch_count !== 32'd7) begin n_bad++; $display("FAIL misaligned_count: got %0d want 7", fetch_count); end
      redirect_target = 32'd8; stall = 1'b1;
      repeat (3) step_clk();
      n_cmp++; if (fetch_error !== 1'b1 || if_valid !== 1'b0) begin n_bad++; $display("FAIL halt_sticky: got err %b v %b want 1 0", fetch_error, if_valid); end
      n_cmp++; if (ProgramCounter !== 32'd16) begin n_bad++; $display("FAIL halt_pc_frozen: got %h want 10", ProgramCounter); end
      do_reset();
      n_cmp++; if (fetch_error !== 1'b0) begin n_bad++; $display("FAIL halt_reset: got err %b want 0", fetch_error); end
      step_clk(); step_clk();
      redirect = 1'b1; redirect_target = 32'h0000_0080;
      step_clk();
      redirect = 1'b0;
      n_cmp++; if (fetch_error !== 1'b1 || if_valid !== 1'b0) begin n_bad++; $display("FAIL range_halt: got err %b v %b want 1 0", fetch_error, if_valid); end
      n_cmp++; if (ProgramCounter !== 32'd8 || fetch_count !== 32'd2) begin n_bad++; $display("FAIL range_halt_state: got pc %h cnt %0d want 8 2", ProgramCounter, fetch_count); end
   endtask

   task automatic test_end_of_memory();
      do_reset();
      repeat (IMEM_WORDS) step_clk();
      n_cmp++; if (if_pc !== LAST_PC || if_valid !== 1'b1) begin n_bad++; $display("FAIL end_last_word: got pc %h v %b want %h 1", if_pc, if_valid, LAST_PC); end
      n_cmp++; if (fetch_count !== 32'(IMEM_WORDS - 1) || fetch_error !== 1'b0) begin n_bad++; $display("FAIL end_before_halt: got cnt %0d err %b want %0d 0", fetch_count, fetch_error, IMEM_WORDS - 1); end
      step_clk();
      n_cmp++; if (fetch_error !== 1'b1 || if_valid !== 1'b0) begin n_bad++; $display("FAIL end_halt: got err %b v %b want 1 0", fetch_error, if_valid); end
      repeat (3) step_clk();
      n_cmp++; if (ProgramCounter !== LAST_PC || fetch_count !== 32'(IMEM_WORDS)) begin n_bad++; $display("FAIL end_frozen: got pc %h cnt %0d want %h %0d", ProgramCounter, fetch_count, LAST_PC, IMEM_WORDS); end
   endtask

   task automatic test_async_reset();
      do_reset();
      repeat (6) step_clk();
      stall = 1'b1;
      step_clk();
      #2;
      reset = 1'b1;
      #1;
      n_cmp++; if (ProgramCounter !== 32'h0 || if_pc !== 32'h0) begin n_bad++; $display("FAIL async_pc: got pc %h if_pc %h want 0 0", ProgramCounter, if_pc); end
      n_cmp++; if (if_valid !== 1'b0 || fetch_error !== 1'b0 || fetch_count !== 32'h0) begin n_bad++; $display("FAIL async_flags: got v %b err %b cnt %0d want 0 0 0", if_valid, fetch_error, fetch_count); end
      @(negedge clk);
      reset = 1'b0; stall = 1'b0;
   endtask

   task automatic model_reset();
      m_npc = 32'h0; m_if_pc = 32'h0; m_valid = 1'b0; m_halted = 1'b0; m_count = 32'h0;
   endtask

   // One clock edge of the fetch rules, applied to the model.
   task automatic model_edge(input logic s, input logic r, input logic [31:0] t);
      if (m_halted) return;
      if (r) begin
         if (m_valid && !s) m_count++;
         m_valid = 1'b0;
         if (t % 4 != 0 || longint'(t) >= longint'(4 * IMEM_WORDS)) m_halted = 1'b1;
         else m_npc = t;
      end else if (m_valid && s) begin
         // held
      end else if (m_valid && m_if_pc == LAST_PC) begin
         m_count++;
         m_valid  = 1'b0;
         m_halted = 1'b1;
      end else begin
         if (m_valid) m_count++;
         m_if_pc = m_npc;
         m_valid = 1'b1;
         if (m_npc != LAST_PC) m_npc = m_npc + 32'd4;
      end
   endtask

   task automatic test_random();
      logic        s, r;
      logic [31:0] t, exp_pc;
      int          halt_cycles;
      for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;
      do_reset();
      model_reset();
      halt_cycles = 0;
      for (int n = 0; n < 1500; n++) begin
         if (halt_cycles > 3) begin
            do_reset();
            model_reset();
            halt_cycles = 0;
         end
         s = ($urandom_range(99) < 30);
         r = ($urandom_range(99) < 8);
         case ($urandom_range(19))
            0:       t = $urandom;
            1:       t = {$urandom_range(31), 2'b10};
            2:       t = LAST_PC - 32'(4 * $urandom_range(2));
            default: t = {23'h0, 7'($urandom_range(IMEM_WORDS - 1)), 2'b00};
         endcase
         stall = s; redirect = r; redirect_target = t;
         #1;
         exp_pc = (s && m_valid) ? m_if_pc : m_npc;
         n_cmp++; if (ProgramCounter !== exp_pc) begin n_bad++; $display("FAIL rand_pc: cycle %0d got %h want %h", n, ProgramCounter, exp_pc); end
         step_clk();
         model_edge(s, r, t);
         if (m_halted) halt_cycles++;
         n_cmp++; if (if_valid !== m_valid) begin n_bad++; $display("FAIL rand_valid: cycle %0d got %b want %b", n, if_valid, m_valid); end
         n_cmp++; if (fetch_error !== m_halted) begin n_bad++; $display("FAIL rand_error: cycle %0d got %b want %b", n, fetch_error, m_halted); end
         n_cmp++; if (fetch_count !== m_count) begin n_bad++; $display("FAIL rand_count: cycle %0d got %0d want %0d", n, fetch_count, m_count); end
         if (m_valid) begin
            n_cmp++; if (if_pc !== m_if_pc) begin n_bad++; $display("FAIL rand_if_pc: cycle %0d got %h want %h", n, if_pc, m_if_pc); end
            n_cmp++; if (if_instruction !== mem[m_if_pc[6:2]]) begin n_bad++; $display("FAIL rand_instr: cycle %0d got %h want %h", n, if_instruction, mem[m_if_pc[6:2]]); end
         end
      end
      stall = 1'b0; redirect = 1'b0;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
      load_spec_program();
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_bad_redirect();
      test_end_of_memory();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_instruction_fetch_unit

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 32, the number of 32-bit words in instruction memory; the legal byte range is 0 .. 4*IMEM_WORDS-4.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ProgramCounter, output, 32 bits: byte address presented to instruction memory.
REQ-006 SHALL have port instruction, input, 32 bits: word returned by instruction memory, registered one cycle after ProgramCounter.
REQ-007 SHALL have port stall, input, 1 bit: consumer backpressure; the consumer accepts an instruction on a rising edge where if_valid=1 and stall=0.
REQ-008 SHALL have port redirect, input, 1 bit: branch/jump request.
REQ-009 SHALL have port redirect_target, input, 32 bits: the new fetch byte address.
REQ-010 SHALL have port if_instruction, output, 32 bits: fetched word, a direct pass-through of instruction.
REQ-011 SHALL have port if_pc, output, 32 bits: byte address of if_instruction.
REQ-012 SHALL have port if_valid, output, 1 bit: if_instruction/if_pc are valid.
REQ-013 SHALL have port fetch_error, output, 1 bit: sticky fault flag.
REQ-014 SHALL have port fetch_count, output, 32 bits: count of accepted instructions, wrapping modulo 2^32.

Function
REQ-015 SHALL hold an internal next-PC register npc and drive ProgramCounter = (stall && if_valid) ? if_pc : npc.
- When stalled, memory re-reads the word already presented, so if_instruction stays stable.
REQ-016 SHALL implement the states RUN and HALT, with RUN as the reset state.
REQ-017 In RUN with redirect=0 and no effective stall, each edge SHALL perform if_pc<=npc, if_valid<=1, npc<=npc+4.
REQ-018 An effective stall (stall=1 and if_valid=1) SHALL hold npc, if_pc, if_valid and fetch_count.
REQ-019 A stall while if_valid=0 SHALL be ignored, so bubbles collapse.
REQ-020 A redirect in RUN SHALL have priority over stall, and on the edge it SHALL perform npc<=redirect_target and if_valid<=0.
- This gives exactly one bubble cycle.
- if_pc=redirect_target appears with if_valid=1 on the following edge.
REQ-021 If redirect_target[1:0]!=0 or redirect_target>=4*IMEM_WORDS on a redirect, the unit SHALL enter HALT.
REQ-022 If npc+4 would reach 4*IMEM_WORDS, the unit SHALL enter HALT instead of wrapping; the last legal word is still delivered before HALT.
REQ-023 In HALT the unit SHALL force if_valid=0 and fetch_error=1, freeze npc and ProgramCounter, and ignore redirect and stall until reset.
REQ-024 fetch_count SHALL increment by 1 on every edge where if_valid=1 and stall=0, including the edge of a redirect, since the presented instruction is accepted.
REQ-025 Arithmetic SHALL be unsigned 32-bit, and the range check SHALL be performed on the full 32-bit value.

Reset
REQ-026 Asserting reset SHALL immediately, without a clock edge, set:
- npc=if_pc=ProgramCounter=RESET_PC;
- if_valid=0, fetch_error=0, fetch_count=0;
- state=RUN.
REQ-027 Reset asserted mid-stall, mid-redirect or in HALT SHALL discard all pending state.
REQ-028 The first edge after reset release SHALL present if_pc=RESET_PC with if_valid=1.
REQ-029 if_instruction is not reset by this block, and its value SHALL be treated as don't-care while if_valid=0.

Structure
REQ-030 The shared package mips_pkg SHALL hold:
- the state enum (RUN, HALT);
- WORD_BYTES=4;
- the default RESET_PC;
- the NOP encoding 32'h0000_0000.
REQ-031 The alignment and range check SHALL be a sub-module named pc_range_checker, with ports addr and limit_words in and ok out, instantiated twice: once for the redirect path and once for the sequential path.

Verification (RESET_PC=0, IMEM_WORDS=32; memory words 3/4/5 = 8C110008 / 8C120004 / 02324020, all others NOP)
REQ-032 Release reset with no stall -> ProgramCounter 0,4,8,12,...; on the 4th edge if_pc=12, if_instruction=8C110008, if_valid=1, fetch_count=3.
REQ-033 Assert stall for 3 cycles while if_pc=16 -> ProgramCounter=16, if_instruction=8C120004 and fetch_count held; after release, the next edge gives if_pc=20, if_instruction=02324020.
REQ-034 Redirect to 12 while if_pc=20 -> next cycle if_valid=0, then if_pc=12 with 8C110008; redirect together with stall behaves identically.
REQ-035 Redirect to 0x0000000A, and separately to 0x00000080 -> fetch_error=1 and if_valid=0, which persist through later redirects until reset.
REQ-036 Sequential run to if_pc=124 -> word 124 delivered, then HALT with fetch_error=1 and ProgramCounter frozen.
REQ-037 Assert reset between clock edges mid-run -> all outputs take the REQ-026 values before the next edge.
